// File: rtl/reg_pkg.sv
// Shared definitions for the base register library: skid-buffer state encoding
// and buffer depth.
package reg_pkg;

  typedef enum logic [1:0] {
    SKD_EMPTY = 2'b00,
    SKD_BUSY  = 2'b01,
    SKD_FULL  = 2'b10
  } skd_state_e;

  localparam int SKD_DEPTH = 2;

endpackage

// File: rtl/reg_en_arst.sv
// Data register with load enable and asynchronous active-high reset to RST_VAL.
module reg_en_arst #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_skd.sv
// Two-entry skid buffer: full-throughput valid/ready pipeline stage whose
// o_rdy and o_vld are decoded only from registered state.
module reg_skd
  import reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_data
);

  skd_state_e            state_q;
  skd_state_e            state_d;
  logic                  in_fire;
  logic                  out_fire;
  logic                  main_en;
  logic                  main_from_skid;
  logic                  skid_en;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  assign in_fire  = i_vld & o_rdy;
  assign out_fire = o_vld & i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= SKD_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush returns to EMPTY without touching storage; stale words stay hidden.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (i_flush) begin
      state_d = SKD_EMPTY;
    end else begin
      case (state_q)
        SKD_EMPTY: begin
          if (in_fire) begin
            state_d = SKD_BUSY;
            main_en = 1'b1;
          end
        end
        SKD_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            state_d = SKD_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = SKD_EMPTY;
          end
        end
        SKD_FULL: begin
          if (out_fire) begin
            state_d        = SKD_BUSY;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = SKD_EMPTY;
      endcase
    end
  end

  always_comb begin
    o_vld = (state_q != SKD_EMPTY);
    o_rdy = (state_q != SKD_FULL);
  end

  assign main_d = main_from_skid ? skid_q : i_data;

  reg_en_arst #(
    .DATA_WIDTH (DATA_WIDTH),
    .RST_VAL    ('0)
  ) u_main (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  reg_en_arst #(
    .DATA_WIDTH (DATA_WIDTH),
    .RST_VAL    ('0)
  ) u_skid (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (skid_en),
    .d_i   (i_data),
    .q_o   (skid_q)
  );

  assign o_data = main_q;

endmodule

// File: tb/tb_reg_skd.sv
// Bench for reg_skd: directed scenarios plus random traffic against a
// queue-based model of a two-deep FIFO stage.
module tb_reg_skd;
  import reg_pkg::*;

  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_flush;
  logic          i_vld;
  logic          o_rdy;
  logic [DW-1:0] i_data;
  logic          o_vld;
  logic          i_rdy;
  logic [DW-1:0] o_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl_q[$];

  reg_skd #(.DATA_WIDTH(DW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_data  (i_data),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_data  (o_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Outputs must match the model: valid iff something held, ready iff not full,
  // data is the oldest held word.
  task automatic chk_outputs(input string tag);
    chk({tag, ".vld"}, DW'(o_vld), DW'(mdl_q.size() > 0));
    chk({tag, ".rdy"}, DW'(o_rdy), DW'(mdl_q.size() < SKD_DEPTH));
    if (mdl_q.size() > 0) chk({tag, ".data"}, o_data, mdl_q[0]);
  endtask

  // Drive one cycle's inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic vld, input logic [DW-1:0] data, input logic rdy,
                       input logic flush, input string tag);
    logic in_f, out_f;
    i_vld   = vld;
    i_data  = data;
    i_rdy   = rdy;
    i_flush = flush;
    in_f  = vld && (mdl_q.size() < SKD_DEPTH);
    out_f = rdy && (mdl_q.size() > 0);
    @(posedge i_clk);
    if (flush) begin
      mdl_q.delete();
    end else begin
      if (out_f) void'(mdl_q.pop_front());
      if (in_f) mdl_q.push_back(data);
    end
    @(negedge i_clk);
    chk_outputs(tag);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b0; i_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst.vld", DW'(o_vld), '0);
    chk("rst.rdy", DW'(o_rdy), 1);
    chk("rst.data", o_data, '0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_outputs("rst.rel");

    // Reset mid-cycle while BUSY
    cycle(1'b1, 32'hFFFF0000, 1'b0, 1'b0, "r1.load");
    i_vld = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("r1.vld", DW'(o_vld), '0);
    chk("r1.rdy", DW'(o_rdy), 1);
    chk("r1.data", o_data, '0);
    mdl_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0, "r1.post");

    // Streaming
    cycle(1'b1, 32'hFFFF0000, 1'b1, 1'b0, "s.w0");
    cycle(1'b1, 32'hFFFF00FF, 1'b1, 1'b0, "s.w1");
    chk("s.w1.lit", o_data, 32'hFFFF00FF);
    cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "s.w2");
    chk("s.w2.lit", o_data, 32'hFFFFFFFF);
    cycle(1'b0, '0, 1'b1, 1'b0, "s.drain");

    // Backpressure and skid
    cycle(1'b1, 32'hA0, 1'b0, 1'b0, "b.a0");
    cycle(1'b1, 32'hB0, 1'b0, 1'b0, "b.b0");
    chk("b.full.rdy", DW'(o_rdy), '0);
    cycle(1'b1, 32'hC0, 1'b0, 1'b0, "b.c0rej");
    chk("b.hold", o_data, 32'hA0);
    cycle(1'b1, 32'hC0, 1'b1, 1'b0, "b.outA");
    chk("b.outA.lit", o_data, 32'hB0);
    cycle(1'b1, 32'hC0, 1'b1, 1'b0, "b.outB");
    chk("b.outB.lit", o_data, 32'hC0);
    cycle(1'b0, '0, 1'b1, 1'b0, "b.drain");

    // Simultaneous in/out while BUSY
    cycle(1'b1, 32'h11, 1'b1, 1'b0, "sim.11");
    cycle(1'b1, 32'h22, 1'b1, 1'b0, "sim.22");
    chk("sim.lit", o_data, 32'h22);
    cycle(1'b0, '0, 1'b1, 1'b0, "sim.drain");

    // Flush from FULL with simultaneous traffic
    cycle(1'b1, 32'h33, 1'b0, 1'b0, "f.33");
    cycle(1'b1, 32'h44, 1'b0, 1'b0, "f.44");
    cycle(1'b1, 32'h55, 1'b1, 1'b1, "f.flush");
    chk("f.vld.lit", DW'(o_vld), '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "f.idle");

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), DW'($urandom), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 31) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
